dmem_responder: RTL
===================

# dmem_responder

Word-addressed data-memory responder on the far end of the RV32 core's data port: it consumes `mem_ctrl`/`mem_addr`/`mem_out` from the core's data cache and returns read data on `mem_in`. It stores words in an internal array, accepts one request per cycle with no backpressure, and returns reads after a fixed, parameterised latency. It replaces ad-hoc testbench memories and serves as the on-chip data RAM.

## Interface
- `XLEN`, 32, data/address width
- `DEPTH_WORDS`, 1024, number of XLEN-bit words stored
- `RD_LATENCY`, 2, cycles from request sample edge to read data valid; legal range 1..4
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `mem_ctrl`  in  2  request: 2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 reserved
- `mem_addr`  in  XLEN  byte address of the request
- `mem_out`  in  XLEN  write data driven by the core
- `mem_in`  out  XLEN  read data returned to the core
- `rd_valid`  out  1  one-cycle pulse: `mem_in` carries a completed read
- `err`  out  1  sticky error flag
- `err_addr`  out  XLEN  address of the first erroring request

## Operation
- A request is sampled on every rising edge; there is no stall path. Word index = (`mem_addr` − `BASE_ADDR`) >> 2.
- Write: the array is updated at the sample edge. A read sampled at the next edge or later sees the new data.
- Read: the array is read at the sample edge. The word then travels an (RD_LATENCY−1)-deep valid/data shift pipeline.
  - The data is a snapshot: a later write to the same address does not alter an in-flight read.
- `mem_in` holds the last completed read data until the next completion.
- Reserved code 2'b11 behaves as idle: no write and no read.
- Out of range (`mem_addr` < `BASE_ADDR`, or index ≥ `DEPTH_WORDS`):
  - a write is dropped;
  - a read completes normally with data 0.
- `mem_addr[1:0]` is ignored for the array access.

## Timing
- Reset values: `mem_in`=0, `rd_valid`=0, `err`=0, `err_addr`=0, and all pipeline valids=0. Array contents are not reset.
- Reset asserted mid-operation: all in-flight reads are discarded. No `rd_valid` is produced for them after reset deasserts.
- Read sampled at edge N: `rd_valid`=1 and `mem_in` valid after edge N+RD_LATENCY−1, for one cycle.
  - With RD_LATENCY=1 this is a registered read, valid in the cycle after the sample edge.
- Back-to-back reads yield back-to-back `rd_valid` pulses, in request order.
- Write at edge N followed by a read of the same address at edge N+1 returns the written data.
- `err` and `err_addr` update at the edge that samples the offending request.

## Configuration
- `DMEM_RESP_ERR_EN` defined: `err` is set on any of the following, and `err_addr` captures `mem_addr` of the first such event:
  - out-of-range read or write;
  - read or write with `mem_addr[1:0]` ≠ 0;
  - `mem_ctrl`=2'b11.
  - Both `err` and `err_addr` stay set until reset.
- `DMEM_RESP_ERR_EN` undefined: the detection logic is removed; `err` and `err_addr` are tied to 0. Data behaviour is identical in both builds.

## Structure
- Shared package `dmem_pkg`:
  - `mem_ctrl` encodings `MEM_IDLE`, `MEM_READ`, `MEM_WRITE`, `MEM_RSVD`;
  - the legal RD_LATENCY bounds.
  - The core's data cache imports the same package.
- One sub-module, `dmem_rd_pipe`: a parameterised-depth valid+data shift register with async reset of the valid bits. The top level holds the array, address decode and error logic.

## Test plan
- Reset, write 0x1234_5678 to 0x10, read 0x10 one cycle later (RD_LATENCY=2) -> `rd_valid` one cycle after the read sample edge, `mem_in`=0x1234_5678.
- Reads of 0x0, 0x4, 0x8 on consecutive edges holding 0xA, 0xB, 0xC -> three consecutive `rd_valid` pulses returning 0xA, 0xB, 0xC; `mem_in` holds 0xC afterwards.
- Read 0x20 (holding 0x1), then write 0x2 to 0x20 on the next edge -> the read returns 0x1; a subsequent read returns 0x2.
- Read 0x1000 with DEPTH_WORDS=1024 -> `mem_in`=0 with `rd_valid`. With ERR_EN: `err`=1, `err_addr`=0x1000. A second bad access to 0x2002 leaves `err_addr`=0x1000.
- Two reads in flight (RD_LATENCY=4), `rst_n` pulsed low -> `rd_valid` stays 0 and `mem_in`=0 immediately on assertion.
- `mem_ctrl`=2'b11 with address 0x30 -> the array is unchanged (a later read of 0x30 returns the prior value) and no `rd_valid`. With ERR_EN: `err`=1, `err_addr`=0x30.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory port.
//   mem_ctrl_e  - request encodings driven on mem_ctrl by the core's data cache
//   RD_LAT_MIN/RD_LAT_MAX - legal bounds of the responder's read latency
//   rd_lat_legal() - helper used for the elaboration-time latency check
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_ctrl_e;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// dmem_rd_pipe: DEPTH-stage valid+data shift register for read responses.
// Stage 0 captures the array read at the request sample edge; the last stage
// drives the responder outputs. A stage's data only loads when a valid word
// enters it, so the last stage holds the most recent completed read.
// Ports:
//   clk, rst_n            - clock, async active-low reset (clears valids and data)
//   in_valid, in_data     - read launched this cycle and its array data
//   out_valid, out_data   - completed read pulse and held read data
module dmem_rd_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                // Gate data moves on valid so idle cycles never disturb held data.
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM on the core's data port.
// Accepts one request per cycle (no backpressure); writes update the array at
// the sample edge, reads snapshot the array at the sample edge and complete
// RD_LATENCY-1 edges later. Out-of-range writes are dropped, out-of-range reads
// return 0. Reserved requests behave as idle.
// Optional feature macro: DMEM_RESP_ERR_EN enables the sticky error flag and
// first-error address capture; when undefined err/err_addr are tied to 0.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   mem_ctrl    - request code (idle/read/write/reserved)
//   mem_addr    - byte address of the request
//   mem_out     - write data from the core
//   mem_in      - read data returned to the core (held between completions)
//   rd_valid    - one-cycle completion pulse for mem_in
//   err         - sticky error flag
//   err_addr    - address of the first erroring request
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter int unsigned     RD_LATENCY  = 2,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      mem_ctrl,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_out,
    output logic [XLEN-1:0] mem_in,
    output logic            rd_valid,
    output logic            err,
    output logic [XLEN-1:0] err_addr
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (!rd_lat_legal(RD_LATENCY)) begin : g_lat_check
        $error("dmem_responder: RD_LATENCY outside legal range");
    end

    // Request decode
    mem_ctrl_e       req;
    logic            is_rd;
    logic            is_wr;
    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] word_off;
    logic [IDX_W-1:0] word_idx;
    logic            in_range;

    assign req      = mem_ctrl_e'(mem_ctrl);
    assign is_rd    = (req == MEM_READ);
    assign is_wr    = (req == MEM_WRITE);
    assign offset   = mem_addr - BASE_ADDR;
    assign word_off = offset >> 2;
    assign word_idx = word_off[IDX_W-1:0];
    // Below-base addresses wrap to large offsets, but check explicitly anyway.
    assign in_range = (mem_addr >= BASE_ADDR) && (word_off < XLEN'(DEPTH_WORDS));

    // Storage: no reset on the array contents.
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (is_wr && in_range) begin
            mem[word_idx] <= mem_out;
        end
    end

    // Read launch: combinational array read captured by pipeline stage 0.
    logic [XLEN-1:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (in_range) begin
            rd_data = mem[word_idx];
        end
    end

    dmem_rd_pipe #(
        .DEPTH (RD_LATENCY),
        .WIDTH (XLEN)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (is_rd),
        .in_data   (rd_data),
        .out_valid (rd_valid),
        .out_data  (mem_in)
    );

`ifdef DMEM_RESP_ERR_EN
    logic            err_q;
    logic [XLEN-1:0] err_addr_q;
    logic            bad_req;

    always_comb begin
        bad_req = 1'b0;
        if (is_rd || is_wr) begin
            bad_req = !in_range || (mem_addr[1:0] != 2'b00);
        end else if (req == MEM_RSVD) begin
            bad_req = 1'b1;
        end
    end

    // Only the first offending request is recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (bad_req && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= mem_addr;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;
`else
    assign err      = 1'b0;
    assign err_addr = '0;
`endif

endmodule
